// File: rtl/fpcvt_pipe.sv
// fpcvt_pipe: three-stage pipelined converter from a DW-bit two's-complement
// integer to a small sign / exponent / significand float. The result value is
// out_f * 2^out_e with sign out_s.
//   S1: sign capture and magnitude
//   S2: leading-one detect, significand extraction, round bit (+ sticky)
//   S3: rounding, carry renormalisation, saturation, registered outputs
// Handshake: valid/ready on both sides. Each stage advances when its
// successor is empty or advancing, so bubbles collapse.
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     input handshake, in_data = DW-bit sample
//   out_valid/out_ready   output handshake
//   out_s/out_e/out_f     sign, EW-bit exponent, FW-bit significand
//   out_sat               result saturated (overflow or most-negative input)
//   busy                  any pipeline stage holds a sample
// Build option: define FPCVT_RNE_EN for round-to-nearest-even; otherwise the
// significand is incremented whenever the round bit is set.
module fpcvt_pipe #(
    parameter int DW = 12,
    parameter int EW = 3,
    parameter int FW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_s,
    output logic [EW-1:0] out_e,
    output logic [FW-1:0] out_f,
    output logic          out_sat,
    output logic          busy
);

    localparam int            PW      = $clog2(DW) + 1;
    localparam logic [PW-1:0] FW_P    = PW'(FW);
    localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

    // Stage registers
    logic          v1_r, s1_r, sat1_r;
    logic [DW-1:0] m1_r;
    logic          v2_r, s2_r, sat2_r, r2_r;
    logic [EW:0]   e2_r;
    logic [FW-1:0] f2_r;
`ifdef FPCVT_RNE_EN
    logic          st2_r;
`endif
    logic          v3_r;

    // Handshake: a stage can take new data when empty or when it is moving on
    logic ready1_s, ready2_s, ready3_s;
    assign ready3_s  = !v3_r || out_ready;
    assign ready2_s  = !v2_r || ready3_s;
    assign ready1_s  = !v1_r || ready2_s;
    assign in_ready  = !rst && ready1_s;
    assign out_valid = v3_r;
    assign busy      = v1_r || v2_r || v3_r;

    // S1 combinational magnitude; the most-negative code wraps to 100..0,
    // which is harmless because that case is flagged for saturation.
    logic [DW-1:0] mag_s;
    assign mag_s = in_data[DW-1] ? (~in_data + {{(DW-1){1'b0}}, 1'b1}) : in_data;

    // S1 register: sign, magnitude and most-negative flag
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r   <= 1'b0;
            s1_r   <= 1'b0;
            sat1_r <= 1'b0;
            m1_r   <= '0;
        end else if (ready1_s) begin
            v1_r   <= in_valid;
            s1_r   <= in_data[DW-1];
            sat1_r <= (in_data == MIN_NEG);
            m1_r   <= mag_s;
        end
    end

    // S2 combinational signals
    logic [PW-1:0] lead_s, sh_s;
    logic [DW-1:0] shifted_s, rshift_s;
    logic [EW:0]   e_s;
    logic [FW-1:0] f_s;
    logic          r_s;
`ifdef FPCVT_RNE_EN
    logic [DW-1:0] mask_s;
    logic          st_s;
`endif

    // S2 leading-one detect and extraction of F, round bit and sticky
    always_comb begin
        lead_s    = '0;
        sh_s      = '0;
        shifted_s = '0;
        rshift_s  = '0;
        e_s       = '0;
        f_s       = '0;
        r_s       = 1'b0;
`ifdef FPCVT_RNE_EN
        mask_s    = '0;
        st_s      = 1'b0;
`endif
        for (int i = 0; i < DW; i++) begin
            lead_s = m1_r[i] ? PW'(i) : lead_s;
        end
        if (lead_s < FW_P) begin
            // Small magnitudes (including zero) are exact with E=0
            f_s = m1_r[FW-1:0];
        end else begin
            sh_s      = lead_s - FW_P + PW'(1);
            e_s       = (EW+1)'(sh_s);
            shifted_s = m1_r >> sh_s;
            f_s       = shifted_s[FW-1:0];
            rshift_s  = m1_r >> (sh_s - PW'(1));
            r_s       = rshift_s[0];
`ifdef FPCVT_RNE_EN
            mask_s    = (DW'(1) << (sh_s - PW'(1))) - DW'(1);
            st_s      = |(m1_r & mask_s);
`endif
        end
    end

    // S2 register: exponent (one extra bit for overflow), significand, R, S
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_r   <= 1'b0;
            s2_r   <= 1'b0;
            sat2_r <= 1'b0;
            e2_r   <= '0;
            f2_r   <= '0;
            r2_r   <= 1'b0;
`ifdef FPCVT_RNE_EN
            st2_r  <= 1'b0;
`endif
        end else if (ready2_s) begin
            v2_r   <= v1_r;
            s2_r   <= s1_r;
            sat2_r <= sat1_r;
            e2_r   <= e_s;
            f2_r   <= f_s;
            r2_r   <= r_s;
`ifdef FPCVT_RNE_EN
            st2_r  <= st_s;
`endif
        end
    end

    // S3 combinational signals
    logic          inc_s, ovf_s;
    logic [FW:0]   sum_s;
    logic [EW:0]   e_rnd_s;
    logic [FW-1:0] f_rnd_s;

    // S3 rounding increment, carry renormalisation and overflow detect
    always_comb begin
`ifdef FPCVT_RNE_EN
        inc_s = r2_r && (st2_r || f2_r[0]);
`else
        inc_s = r2_r;
`endif
        sum_s = {1'b0, f2_r} + {{FW{1'b0}}, inc_s};
        if (sum_s[FW]) begin
            f_rnd_s = {1'b1, {(FW-1){1'b0}}};
            e_rnd_s = e2_r + {{EW{1'b0}}, 1'b1};
        end else begin
            f_rnd_s = sum_s[FW-1:0];
            e_rnd_s = e2_r;
        end
        ovf_s = sat2_r || e_rnd_s[EW];
    end

    // S3 output register; holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            v3_r    <= 1'b0;
            out_s   <= 1'b0;
            out_e   <= '0;
            out_f   <= '0;
            out_sat <= 1'b0;
        end else if (ready3_s) begin
            v3_r <= v2_r;
            if (v2_r) begin
                out_s   <= s2_r;
                out_e   <= ovf_s ? {EW{1'b1}} : e_rnd_s[EW-1:0];
                out_f   <= ovf_s ? {FW{1'b1}} : f_rnd_s;
                out_sat <= ovf_s;
            end
        end
    end

endmodule

// File: tb/tb_fpcvt_pipe.sv
// Scoreboard bench for fpcvt_pipe: stimulus pushes expected results into a
// queue, an independent monitor pops and compares on every consumed output.
module tb_fpcvt_pipe;

    localparam int DW = 12;
    localparam int EW = 3;
    localparam int FW = 4;

    typedef struct packed {
        logic          s;
        logic [EW-1:0] e;
        logic [FW-1:0] f;
        logic          sat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, out_valid, out_ready;
    logic          out_s, out_sat, busy;
    logic [DW-1:0] in_data;
    logic [EW-1:0] out_e;
    logic [FW-1:0] out_f;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   check_lat = 1'b0;
    exp_t exp_q[$];
    int   acc_q[$];

    fpcvt_pipe #(.DW(DW), .EW(EW), .FW(FW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_e(out_e), .out_f(out_f), .out_sat(out_sat),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: integer arithmetic on the value, normalising by halving
    function automatic exp_t ref_model(input logic [DW-1:0] d);
        exp_t r;
        int v, m, e, q, rem, half;
        bit up;
        v = int'($signed(d));
        r.s = d[DW-1];
        if (v == -(1 << (DW-1))) begin
            r.e = '1; r.f = '1; r.sat = 1'b1;
            return r;
        end
        m = (v < 0) ? -v : v;
        e = 0;
        q = m;
        while (q >= (1 << FW)) begin
            q = q >> 1;
            e++;
        end
        rem = m - (q << e);
        up = 1'b0;
        if (e > 0) begin
            half = 1 << (e - 1);
`ifdef FPCVT_RNE_EN
            up = (rem > half) || (rem == half && (q % 2) == 1);
`else
            up = (rem >= half);
`endif
        end
        q = q + int'(up);
        if (q == (1 << FW)) begin
            q = 1 << (FW - 1);
            e++;
        end
        if (e > (1 << EW) - 1) begin
            r.e = '1; r.f = '1; r.sat = 1'b1;
        end else begin
            r.e = EW'(e); r.f = FW'(q); r.sat = 1'b0;
        end
        return r;
    endfunction

    // One cycle of stimulus; pushes the expectation if the sample is taken
    task automatic step(input logic v, input logic [DW-1:0] d, input logic ordy,
                        input exp_t ex, output logic acc);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
        if (acc) begin
            exp_q.push_back(ex);
            acc_q.push_back(cyc + 1);
        end
    endtask

    task automatic drain();
        logic a;
        for (int k = 0; k < 100 && exp_q.size() != 0; k++)
            step(1'b0, '0, 1'b1, '0, a);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results still pending, required 0", exp_q.size());
        end
    endtask

    // Monitor: compares consumed results, hold stability and latency
    initial begin
        exp_t got, held_v, ex;
        int   ac;
        bit   held;
        held = 1'b0;
        held_v = '0;
        forever begin
            @(negedge clk);
            #2;
            got = {out_s, out_e, out_f, out_sat};
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    checks++;
                    if (!out_valid || got != held_v) begin
                        errors++;
                        $display("FAIL hold: got v=%b %h, required v=1 %h", out_valid, got, held_v);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_result: got %h, required no output", got);
                    end else begin
                        ex = exp_q.pop_front();
                        ac = acc_q.pop_front();
                        if (got != ex) begin
                            errors++;
                            $display("FAIL result: got s=%b e=%b f=%b sat=%b, required s=%b e=%b f=%b sat=%b",
                                     got.s, got.e, got.f, got.sat, ex.s, ex.e, ex.f, ex.sat);
                        end
                        if (check_lat) begin
                            checks++;
                            if (cyc - ac != 2) begin
                                errors++;
                                $display("FAIL latency: got %0d edges after accept edge, required 2", cyc - ac);
                            end
                        end
                    end
                end
                held = out_valid && !out_ready;
                held_v = got;
            end
        end
    end

    initial begin
        logic          a;
        logic [DW-1:0] sd[8];
        logic [DW-1:0] d;
        int            idx;
        exp_t          ex;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (out_valid || busy || out_s || out_sat || out_e != '0 || out_f != '0 || in_ready) begin
            errors++;
            $display("FAIL reset_state: got v=%b busy=%b rdy=%b out=%b%b%b%b, required all 0",
                     out_valid, busy, in_ready, out_s, out_e, out_f, out_sat);
        end

        // First sample offered on the very edge after reset falls
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1; in_data = 12'h001; out_ready = 1'b1;
        check_lat = 1'b1;
        #1;
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL first_accept: in_ready got %b, required 1", in_ready);
        end else begin
            exp_q.push_back('{s:1'b0, e:3'b000, f:4'b0001, sat:1'b0});
            acc_q.push_back(cyc + 1);
        end
        step(1'b1, 12'h03C, 1'b1, '{s:1'b0, e:3'b010, f:4'b1111, sat:1'b0}, a);
        step(1'b1, 12'h9BF, 1'b1, '{s:1'b1, e:3'b111, f:4'b1101, sat:1'b0}, a);
        step(1'b1, 12'h800, 1'b1, '{s:1'b1, e:3'b111, f:4'b1111, sat:1'b1}, a);
        step(1'b1, 12'h7FF, 1'b1, '{s:1'b0, e:3'b111, f:4'b1111, sat:1'b1}, a);
        step(1'b1, 12'h07D, 1'b1, '{s:1'b0, e:3'b100, f:4'b1000, sat:1'b0}, a);
`ifdef FPCVT_RNE_EN
        step(1'b1, 12'h02A, 1'b1, '{s:1'b0, e:3'b010, f:4'b1010, sat:1'b0}, a);
`else
        step(1'b1, 12'h02A, 1'b1, '{s:1'b0, e:3'b010, f:4'b1011, sat:1'b0}, a);
`endif
        step(1'b1, 12'h02E, 1'b1, '{s:1'b0, e:3'b010, f:4'b1100, sat:1'b0}, a);
        step(1'b1, 12'h000, 1'b1, '{s:1'b0, e:3'b000, f:4'b0000, sat:1'b0}, a);
        step(1'b1, 12'hFFF, 1'b1, '{s:1'b1, e:3'b000, f:4'b0001, sat:1'b0}, a);
        drain();
        check_lat = 1'b0;

        // Backpressure: 8 samples offered while the output is blocked
        for (int i = 0; i < 8; i++) sd[i] = DW'($urandom);
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            step(1'b1, sd[idx], 1'b0, ref_model(sd[idx]), a);
            if (a) idx++;
        end
        checks++;
        if (idx != 3 || in_ready) begin
            errors++;
            $display("FAIL stall_accept: accepted %0d in_ready=%b, required 3 and 0", idx, in_ready);
        end
        for (int c = 0; c < 100 && idx < 8; c++) begin
            step(1'b1, sd[idx], 1'b1, ref_model(sd[idx]), a);
            if (a) idx++;
        end
        drain();

        // Reset with two samples in flight
        step(1'b1, 12'h123, 1'b1, ref_model(12'h123), a);
        step(1'b1, 12'hABC, 1'b1, ref_model(12'hABC), a);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        exp_q.delete();
        acc_q.delete();
        #1;
        checks++;
        if (in_ready) begin
            errors++;
            $display("FAIL rst_in_ready: got %b, required 0", in_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid || busy) begin
            errors++;
            $display("FAIL mid_reset: out_valid=%b busy=%b, required 0 0", out_valid, busy);
        end
        rst = 1'b0;
        repeat (6) step(1'b0, '0, 1'b1, '0, a);
        check_lat = 1'b1;
        step(1'b1, 12'h03C, 1'b1, '{s:1'b0, e:3'b010, f:4'b1111, sat:1'b0}, a);
        drain();
        check_lat = 1'b0;

        // Random traffic with random gaps and random backpressure
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0:       d = 12'h800;
                1:       d = 12'h7FF;
                2:       d = DW'($urandom_range(0, 40));
                default: d = DW'($urandom);
            endcase
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0, ref_model(d), a);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
